// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Mode controller for the stopwatch. Decodes start/pause and lap/reset
//   button presses (short and long) into an IDLE/RUN/PAUSE/LAP state machine.
//   It drives the time counter enable and clear, captures lap splits, and
//   selects live or frozen time for the 7-segment driver.
//
// Ports:
//   clk           display-rate clock, rising edge
//   rst_n         asynchronous active-low reset
//   start_pause_n debounced start/pause button, active-low
//   lap_reset_n   debounced lap/reset button, active-low
//   time_bcd      live counter value {mt, mo, st, so}, BCD
//   at_max        counter is at 59:59
//   count_en      enable to time counter (RUN, LAP)
//   clear         one-cycle pulse zeroing the time counter
//   freeze        display shows captured lap value (LAP)
//   disp_bcd      freeze ? lap_reg : time_bcd
//   state         IDLE=0, RUN=1, PAUSE=2, LAP=3
module stopwatch_ctrl #(
    parameter int unsigned LONG_PRESS_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_pause_n,
    input  logic        lap_reset_n,
    input  logic [15:0] time_bcd,
    input  logic        at_max,
    output logic        count_en,
    output logic        clear,
    output logic        freeze,
    output logic [15:0] disp_bcd,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [15:0] LONG_MAX = 16'(LONG_PRESS_CYCLES);
    localparam logic [15:0] LONG_M1  = 16'(LONG_PRESS_CYCLES - 1);

    state_t      state_q;
    state_t      nxt;
    logic        sp_prev, lr_prev;
    // A button only becomes eligible for events once it has been seen
    // released after reset; a press held through reset is ignored.
    logic        sp_arm, lr_arm;
    logic [15:0] hold_cnt;
    logic [15:0] lap_reg;

    logic        sp_fall, lr_fall, lr_held, lr_rel;
    logic        raw_long, raw_short;
    logic        ev_long, ev_start, ev_short;
    logic        do_clear, do_cap;

    always_comb begin
        sp_fall   = sp_arm & sp_prev & ~start_pause_n;
        lr_fall   = lr_arm & lr_prev & ~lap_reset_n;
        lr_held   = lr_arm & ~lr_prev & ~lap_reset_n;
        lr_rel    = lr_arm & ~lr_prev & lap_reset_n;
        // Counter reaches LONG_MAX at this edge when it currently holds LONG_M1.
        raw_long  = lr_held & (hold_cnt == LONG_M1);
        raw_short = lr_rel & (hold_cnt < LONG_MAX);
        ev_long   = raw_long;
        ev_start  = sp_fall & ~raw_long;
        ev_short  = raw_short & ~raw_long & ~sp_fall;
    end

    always_comb begin
        nxt      = state_q;
        do_clear = 1'b0;
        do_cap   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev_start) begin
                    nxt = RUN;
                end else if (ev_long || ev_short) begin
                    do_clear = 1'b1;
                end
            end
            RUN, LAP: begin
                if (ev_long) begin
                    nxt      = IDLE;
                    do_clear = 1'b1;
                end else if (at_max || ev_start) begin
                    nxt = PAUSE;
                end else if (ev_short) begin
                    nxt    = LAP;
                    do_cap = 1'b1;
                end
            end
            PAUSE: begin
                if (ev_long || ev_short) begin
                    nxt      = IDLE;
                    do_clear = 1'b1;
                end else if (ev_start && !at_max) begin
                    nxt = RUN;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_en <= 1'b0;
            clear    <= 1'b0;
            freeze   <= 1'b0;
            lap_reg  <= '0;
            hold_cnt <= '0;
            sp_prev  <= 1'b1;
            lr_prev  <= 1'b1;
            sp_arm   <= 1'b0;
            lr_arm   <= 1'b0;
        end else begin
            sp_prev <= start_pause_n;
            lr_prev <= lap_reset_n;
            if (start_pause_n) sp_arm <= 1'b1;
            if (lap_reset_n)   lr_arm <= 1'b1;

            if (lr_fall) begin
                hold_cnt <= 16'd1;
            end else if (lr_held && hold_cnt < LONG_MAX) begin
                hold_cnt <= hold_cnt + 16'd1;
            end

            state_q  <= nxt;
            count_en <= (nxt == RUN) || (nxt == LAP);
            freeze   <= (nxt == LAP);
            clear    <= do_clear;

            if (do_clear) begin
                lap_reg <= '0;
            end else if (do_cap) begin
                lap_reg <= time_bcd;
            end
        end
    end

    assign state    = state_q;
    assign disp_bcd = freeze ? lap_reg : time_bcd;

endmodule
